// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the five-stage RISC-V pipeline.
//
// Sits between the EX/MEM register and writeback. Loads and stores are issued
// to data memory over a req/ready handshake. While an access is outstanding,
// mem_stall holds EX/MEM and all earlier stages. Load data is aligned and
// sign/zero extended here. Store data is lane-replicated with byte enables.
// This module also owns the MEM/WB pipeline register.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   ex_*                   EX/MEM register contents (valid, ALU result/address,
//                          store data, PC+4, rd, controls, funct3)
//   dmem_req/we/addr/
//   wdata/be               data memory request, held stable while BUSY
//   dmem_ready/rdata       access completes / load word
//   mem_stall              hold upstream (combinational)
//   mem_exc                one-cycle pulse: misaligned or illegal-funct3 access
//   wb_*                   MEM/WB register outputs
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_pc_plus4,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_reg,
    input  logic        ex_jump,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_exc,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_reg,
    output logic        wb_jump,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_pc_plus4,
    output logic [4:0]  wb_rd
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    logic        r_state;
    logic [29:0] r_addr_hi;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [31:0] r_alu;
    logic [31:0] r_pc4;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_mem_reg;
    logic        r_jump;

    logic        w_busy;
    logic        w_access;
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_illegal;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_busy   = (r_state == S_BUSY);
    assign w_access = ex_valid & (ex_mem_read | ex_mem_write);

    // Legality check. With both read and write set the access counts as a store.
    always_comb begin
        if (ex_mem_write)
            w_f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
        else
            w_f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                      (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        case (ex_funct3[1:0])
            2'b01:   w_align_ok = ~ex_alu_result[0];
            2'b10:   w_align_ok = (ex_alu_result[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    assign w_illegal = w_access & ~(w_f3_ok & w_align_ok);
    assign w_legal   = w_access & w_f3_ok & w_align_ok;

    // Store lane generation. Loads carry no enables and no data.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        if (ex_mem_write) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ex_alu_result[1:0];
                    w_wdata = {4{ex_store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{ex_store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_store_data;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the captured offset.
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    // Request outputs are gated by BUSY so the bus is quiet between accesses
    // and drops at once when reset forces the state back to IDLE.
    assign dmem_req   = w_busy;
    assign dmem_we    = w_busy & r_we;
    assign dmem_addr  = w_busy ? {r_addr_hi, 2'b00} : 32'd0;
    assign dmem_wdata = w_busy ? r_wdata : 32'd0;
    assign dmem_be    = w_busy ? r_be : 4'b0000;

    // Stall drops in the dmem_ready cycle so retirement and upstream advance
    // share one edge. Gated by rst so it is 0 throughout reset.
    assign mem_stall = ~rst & (w_busy ? ~dmem_ready : w_legal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr_hi     <= 30'd0;
            r_addr_lo     <= 2'd0;
            r_funct3      <= 3'd0;
            r_wdata       <= 32'd0;
            r_be          <= 4'd0;
            r_we          <= 1'b0;
            r_alu         <= 32'd0;
            r_pc4         <= 32'd0;
            r_rd          <= 5'd0;
            r_reg_write   <= 1'b0;
            r_mem_reg     <= 1'b0;
            r_jump        <= 1'b0;
            mem_exc       <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_reg    <= 1'b0;
            wb_jump       <= 1'b0;
            wb_mem_data   <= 32'd0;
            wb_alu_result <= 32'd0;
            wb_pc_plus4   <= 32'd0;
            wb_rd         <= 5'd0;
        end else if (r_state == S_IDLE) begin
            if (w_legal) begin
                r_state     <= S_BUSY;
                r_addr_hi   <= ex_alu_result[31:2];
                r_addr_lo   <= ex_alu_result[1:0];
                r_funct3    <= ex_funct3;
                r_wdata     <= w_wdata;
                r_be        <= w_be;
                r_we        <= ex_mem_write;
                r_alu       <= ex_alu_result;
                r_pc4       <= ex_pc_plus4;
                r_rd        <= ex_rd;
                r_reg_write <= ex_reg_write;
                r_mem_reg   <= ex_mem_reg;
                r_jump      <= ex_jump;
                mem_exc     <= 1'b0;
                wb_valid    <= 1'b0;   // bubble while the access is in flight
            end else begin
                // Non-access or illegal access: straight pass-through. An
                // illegal access never writes the register file.
                mem_exc       <= w_illegal;
                wb_valid      <= ex_valid;
                wb_reg_write  <= ex_reg_write & ~w_illegal;
                wb_mem_reg    <= ex_mem_reg;
                wb_jump       <= ex_jump;
                wb_mem_data   <= 32'd0;
                wb_alu_result <= ex_alu_result;
                wb_pc_plus4   <= ex_pc_plus4;
                wb_rd         <= ex_rd;
            end
        end else begin
            mem_exc <= 1'b0;
            if (dmem_ready) begin
                r_state       <= S_IDLE;
                wb_valid      <= 1'b1;
                wb_reg_write  <= r_reg_write;
                wb_mem_reg    <= r_mem_reg;
                wb_jump       <= r_jump;
                wb_mem_data   <= r_we ? 32'd0 : w_load;
                wb_alu_result <= r_alu;
                wb_pc_plus4   <= r_pc4;
                wb_rd         <= r_rd;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc_plus4;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_reg;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_exc;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_reg;
    logic        wb_jump;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_pc_plus4;
    logic [4:0]  wb_rd;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_reg(ex_mem_reg),
        .ex_jump(ex_jump), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_exc(mem_exc),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_reg(wb_mem_reg),
        .wb_jump(wb_jump), .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
        .wb_pc_plus4(wb_pc_plus4), .wb_rd(wb_rd)
    );

    typedef struct {
        logic [31:0] mem_data;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mreg;
        logic        jmp;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic mreg, input logic jmp, input logic [2:0] f3);
        ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_pc_plus4 = pc4;
        ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        ex_mem_reg = mreg; ex_jump = jmp; ex_funct3 = f3;
    endtask

    task automatic bubble();
        ex_valid = 1'b0; ex_alu_result = 32'd0; ex_store_data = 32'd0; ex_pc_plus4 = 32'd0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_mem_reg = 1'b0; ex_jump = 1'b0; ex_funct3 = 3'd0;
    endtask

    task automatic expect_wb(input logic [31:0] md, input logic [31:0] alu, input logic [31:0] pc4,
                             input logic [4:0] rd, input logic rw, input logic mreg,
                             input logic jmp, input logic exc);
        exp_t e;
        e.mem_data = md; e.alu = alu; e.pc4 = pc4; e.rd = rd;
        e.rw = rw; e.mreg = mreg; e.jmp = jmp; e.exc = exc;
        sb_q.push_back(e);
    endtask

    // Scoreboard side: every retirement pops one expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_mem_data",   wb_mem_data,   e.mem_data);
                chk("wb_alu_result", wb_alu_result, e.alu);
                chk("wb_pc_plus4",   wb_pc_plus4,   e.pc4);
                chk("wb_rd",         {27'd0, wb_rd},        {27'd0, e.rd});
                chk("wb_reg_write",  {31'd0, wb_reg_write}, {31'd0, e.rw});
                chk("wb_mem_reg",    {31'd0, wb_mem_reg},   {31'd0, e.mreg});
                chk("wb_jump",       {31'd0, wb_jump},      {31'd0, e.jmp});
                chk("mem_exc",       {31'd0, mem_exc},      {31'd0, e.exc});
            end
        end
    end

    initial begin
        rst = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        bubble();
        step(); step();
        mid();
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_alu",   wb_alu_result, 32'd0);
        chk("rst_stall",    {31'd0, mem_stall}, 32'd0);
        chk("rst_req",      {31'd0, dmem_req},  32'd0);
        chk("rst_exc",      {31'd0, mem_exc},   32'd0);
        step();
        rst = 1'b0;

        // ALU pass-through
        step();
        drive(32'h1234, 32'd0, 32'h104, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_wb(32'd0, 32'h1234, 32'h104, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        mid();
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        step(); bubble(); mid();
        chk("alu_stall_after", {31'd0, mem_stall}, 32'd0);

        // LB sign-extended, ready in first BUSY cycle
        step();
        drive(32'h1003, 32'd0, 32'h108, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_wb(32'hFFFF_FF80, 32'h1003, 32'h108, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lb_stall_entry", {31'd0, mem_stall}, 32'd1);
        chk("lb_req_entry",   {31'd0, dmem_req},  32'd0);
        step();
        dmem_ready = 1'b1; dmem_rdata = 32'h80FF_7F01;
        mid();
        chk("lb_req",   {31'd0, dmem_req}, 32'd1);
        chk("lb_addr",  dmem_addr, 32'h1000);
        chk("lb_be",    {28'd0, dmem_be}, 32'd0);
        chk("lb_we",    {31'd0, dmem_we}, 32'd0);
        chk("lb_stall_ready", {31'd0, mem_stall}, 32'd0);
        step(); dmem_ready = 1'b0; bubble(); mid();

        // LHU with three wait cycles
        step();
        drive(32'h2002, 32'd0, 32'h10C, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b101);
        expect_wb(32'h0000_BEEF, 32'h2002, 32'h10C, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lhu_stall_entry", {31'd0, mem_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); mid();
            chk("lhu_req_wait",   {31'd0, dmem_req}, 32'd1);
            chk("lhu_addr_wait",  dmem_addr, 32'h2000);
            chk("lhu_stall_wait", {31'd0, mem_stall}, 32'd1);
        end
        step();
        dmem_ready = 1'b1; dmem_rdata = 32'hBEEF_1234;
        mid();
        chk("lhu_req_ready",   {31'd0, dmem_req}, 32'd1);
        chk("lhu_stall_ready", {31'd0, mem_stall}, 32'd0);
        step(); dmem_ready = 1'b0; bubble(); mid();

        // SB at offset 1
        step();
        drive(32'h3001, 32'hAABB_CCDD, 32'h110, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        expect_wb(32'd0, 32'h3001, 32'h110, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        mid();
        chk("sb_we",    {31'd0, dmem_we}, 32'd1);
        chk("sb_be",    {28'd0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        chk("sb_addr",  dmem_addr, 32'h3000);
        step(); dmem_ready = 1'b0; bubble(); mid();

        // SH upper half
        step();
        drive(32'h3002, 32'h1122_3344, 32'h114, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
        expect_wb(32'd0, 32'h3002, 32'h114, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        dmem_ready = 1'b1;
        mid();
        chk("sh_be",    {28'd0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h3344_3344);
        step(); dmem_ready = 1'b0; bubble(); mid();

        // read+write both set: treated as SW
        step();
        drive(32'h3004, 32'hCAFE_F00D, 32'h118, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
        expect_wb(32'd0, 32'h3004, 32'h118, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        dmem_ready = 1'b1; dmem_rdata = 32'h1357_9BDF;
        mid();
        chk("sw_we",    {31'd0, dmem_we}, 32'd1);
        chk("sw_be",    {28'd0, dmem_be}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        step(); dmem_ready = 1'b0; bubble(); mid();

        // aligned LW, one wait cycle
        step();
        drive(32'h3008, 32'd0, 32'h11C, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        expect_wb(32'h7654_3210, 32'h3008, 32'h11C, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); mid();
        chk("lw_stall_wait", {31'd0, mem_stall}, 32'd1);
        step();
        dmem_ready = 1'b1; dmem_rdata = 32'h7654_3210;
        mid();
        step(); dmem_ready = 1'b0; bubble(); mid();

        // misaligned LW
        step();
        drive(32'h4002, 32'd0, 32'h120, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        expect_wb(32'd0, 32'h4002, 32'h120, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        mid();
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        chk("mis_req",   {31'd0, dmem_req},  32'd0);
        step(); bubble(); mid();
        chk("mis_exc_pulse", {31'd0, mem_exc},  32'd1);
        chk("mis_req_after", {31'd0, dmem_req}, 32'd0);
        step(); mid();
        chk("mis_exc_clear", {31'd0, mem_exc}, 32'd0);

        // store with illegal funct3
        step();
        drive(32'h4000, 32'h5555_5555, 32'h124, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100);
        expect_wb(32'd0, 32'h4000, 32'h124, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        mid();
        chk("ilf3_stall", {31'd0, mem_stall}, 32'd0);
        step(); bubble(); mid();
        chk("ilf3_req", {31'd0, dmem_req}, 32'd0);

        // reset while BUSY; ex inputs stay held to show the stall is gated
        step();
        drive(32'h5000, 32'd0, 32'h128, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        step(); mid();
        chk("rb_req_busy", {31'd0, dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rb_req",      {31'd0, dmem_req},  32'd0);
        chk("rb_stall",    {31'd0, mem_stall}, 32'd0);
        chk("rb_wb_valid", {31'd0, wb_valid},  32'd0);
        chk("rb_wb_alu",   wb_alu_result, 32'd0);
        chk("rb_wb_pc4",   wb_pc_plus4,   32'd0);
        chk("rb_wb_rd",    {27'd0, wb_rd}, 32'd0);
        chk("rb_wb_rw",    {31'd0, wb_reg_write}, 32'd0);
        step(); bubble(); step();
        rst = 1'b0;

        // load after reset: LH sign-extended from upper half
        step();
        drive(32'h6002, 32'd0, 32'h12C, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001);
        expect_wb(32'hFFFF_8001, 32'h6002, 32'h12C, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        mid();
        chk("post_rst_stall", {31'd0, mem_stall}, 32'd1);
        step();
        dmem_ready = 1'b1; dmem_rdata = 32'h8001_0000;
        mid();
        chk("post_rst_addr", dmem_addr, 32'h6000);
        step(); dmem_ready = 1'b0; bubble(); mid();

        step(); step(); mid();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, between the EX/MEM register and the writeback stage. It runs loads and stores against the data memory using a ready-based handshake, and stalls upstream while an access is outstanding. It aligns and sign- or zero-extends load data, and generates store byte enables. It also owns the MEM/WB pipeline register, whose outputs feed writeback's data, destination register, write-enable, select and jump inputs directly.

## Interface
- Parameters: none.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_pc_plus4  in  32  PC+4 of the instruction
- ex_rd  in  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_reg, ex_jump  in  1 each  decoded controls
- ex_funct3  in  3  access size/sign
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address; bits [1:0] always 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables; 0000 on loads
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  load word, valid when dmem_ready
- mem_stall  out  1  hold EX/MEM and all earlier stages
- mem_exc  out  1  one-cycle pulse: misaligned access or illegal funct3
- wb_valid, wb_reg_write, wb_mem_reg, wb_jump  out  1 each  MEM/WB register
- wb_mem_data, wb_alu_result, wb_pc_plus4  out  32  MEM/WB register
- wb_rd  out  5  MEM/WB register

## Operation
- An access is defined as `ex_valid & (ex_mem_read | ex_mem_write)`.
- FSM states are IDLE and BUSY. Reset state is IDLE.
- IDLE, no access: the MEM/WB register loads the EX/MEM values at the clock edge.
  - wb_mem_data = 0.
  - wb_valid = ex_valid.
  - mem_stall = 0.
- IDLE, legal access:
  - On the edge, capture addr, funct3, lane data, be, we, rd and the controls into internal registers.
  - Go to BUSY.
  - wb_valid = 0 (a bubble).
  - mem_stall = 1, combinational.
- BUSY:
  - dmem_req = 1, with addr/we/wdata/be driven from the captured registers and held stable.
  - mem_stall = ~dmem_ready.
  - On dmem_ready: load MEM/WB with wb_valid = 1 and wb_mem_data = the extracted load (0 for stores), then go to IDLE.
- Illegal access is any of:
  - funct3 outside {000,001,010,100,101} for loads.
  - funct3 outside {000,001,010} for stores.
  - A halfword with addr[0] = 1.
  - A word with addr[1:0] ≠ 00.
- Illegal access handling:
  - No dmem_req is issued.
  - The instruction passes through like a non-access, with wb_reg_write forced to 0.
  - mem_exc = 1 for exactly one cycle, registered alongside MEM/WB.
- Load extraction:
  - Select the byte at addr[1:0] or the halfword at addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011 << (2·addr[1]), wdata = {2{half}}.
  - SW: be = 1111.
- If ex_mem_read and ex_mem_write are both set, the access is treated as a store.

## Timing
- Reset values: every wb_* output = 0, mem_exc = 0, dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0.
- mem_stall is 0 in reset. It depends only on state and inputs, so it de-asserts asynchronously with rst.
- Reset asserted in BUSY: the access is abandoned and dmem_req drops immediately. The memory must tolerate an aborted request.
- Non-access latency: 1 cycle from EX/MEM to the wb_* outputs.
- Access latency: 1 capture cycle plus N wait cycles. With dmem_ready in the first BUSY cycle, the wb_* outputs are valid 2 cycles after entry.
- Retirement and upstream advance happen on the same edge. mem_stall is already 0 during the dmem_ready cycle, so the next instruction enters IDLE on that edge with no dead cycle.
- While mem_stall = 1, upstream must keep the ex_* inputs stable. The stage ignores changes to them in BUSY.
- No back-pressure from writeback: the wb_* outputs are valid for exactly one cycle per retirement.

## Test plan
- ALU op pass-through:
  - Stimulus: ex_alu_result = 0x1234, rd = 5, reg_write = 1.
  - Response: next cycle wb_valid = 1, wb_alu_result = 0x1234, wb_rd = 5, wb_mem_data = 0; mem_stall never asserts.
- LB, sign-extended:
  - Stimulus: addr 0x1003, dmem_rdata = 0x80FF_7F01, dmem_ready in the first BUSY cycle.
  - Response: dmem_addr = 0x1000, wb_mem_data = 0xFFFF_FF80; mem_stall is high 1 cycle; wb_valid lands 2 cycles after entry.
- LHU:
  - Stimulus: addr 0x2002, dmem_rdata = 0xBEEF_1234, dmem_ready delayed 3 cycles.
  - Response: mem_stall is high 4 cycles, dmem_req and dmem_addr are stable throughout, wb_mem_data = 0x0000_BEEF.
- SB:
  - Stimulus: addr 0x3001, store_data = 0xAABB_CCDD.
  - Response: dmem_we = 1, dmem_be = 0010, dmem_wdata = 0xDDDD_DDDD, wb_mem_data = 0.
- Misaligned LW:
  - Stimulus: addr 0x4002, ex_reg_write = 1.
  - Response: no dmem_req, mem_exc pulses 1 cycle, wb_reg_write = 0, no stall.
- Reset in BUSY:
  - Stimulus: assert rst mid-wait.
  - Response: dmem_req = 0 and mem_stall = 0 immediately, every wb_* output = 0, state IDLE; the next load after reset completes normally.
